// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier producing the full 2*WIDTH-bit product of signed
// or unsigned operands, with a start/busy/done handshake and a WIDTH-bit overflow flag.
module seq_multiplier #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     mul_q, mul_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic                 sgn_q, sgn_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 ovf_q, ovf_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     mcand_mag, b_mag, addend;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   res, fixed;
    logic [WIDTH-1:0]     hi_u;
    logic [WIDTH:0]       hi_s;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        mul_d   = mul_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        sgn_d   = sgn_q;
        prod_d  = prod_q;
        ovf_d   = ovf_q;
        addend  = '0;
        sum     = '0;
        res     = '0;
        fixed   = '0;
        hi_u    = '0;
        hi_s    = '0;

        mcand_mag = (is_signed && mcand[WIDTH-1]) ? -mcand : mcand;
        b_mag     = (is_signed && b[WIDTH-1])     ? -b     : b;

        // Outputs are registered from the current state, so they trail it by one cycle.
        busy_d = (state_q == CALC) || (state_q == FIX);
        done_d = (state_q == DONE);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mcand_d = mcand_mag;
                    mul_d   = b_mag;
                    acc_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    neg_d   = is_signed & (mcand[WIDTH-1] ^ b[WIDTH-1]);
                    sgn_d   = is_signed;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                addend  = mul_q[0] ? mcand_q : '0;
                sum     = {1'b0, acc_q} + {1'b0, addend};
                acc_d   = sum[WIDTH:1];
                mul_d   = {sum[0], mul_q[WIDTH-1:1]};
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                res    = {acc_q, mul_q};
                fixed  = neg_q ? -res : res;
                hi_u   = fixed[2*WIDTH-1:WIDTH];
                hi_s   = fixed[2*WIDTH-1:WIDTH-1];
                prod_d = fixed;
                // Signed results fit only if the upper half plus the sign bit of the lower half agree.
                ovf_d  = sgn_q ? ~((&hi_s) | ~(|hi_s)) : (|hi_u);
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            mul_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            sgn_q   <= 1'b0;
            prod_q  <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mul_q   <= mul_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            sgn_q   <= sgn_d;
            prod_q  <= prod_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign prod     = prod_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at WIDTH=64 and WIDTH=8, using directed corner
// cases plus random operands checked against a wide-integer arithmetic reference.
module tb_seq_multiplier;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        bit          sg;
    } op_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic          start64 = 1'b0, sg64 = 1'b0;
    logic [63:0]   a64 = '0, b64 = '0;
    logic          busy64, done64, ovf64;
    logic [127:0]  prod64;

    logic          start8 = 1'b0, sg8 = 1'b0;
    logic [7:0]    a8 = '0, b8 = '0;
    logic          busy8, done8, ovf8;
    logic [15:0]   prod8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .start(start64), .is_signed(sg64),
        .mcand(a64), .b(b64), .busy(busy64), .done(done64),
        .prod(prod64), .overflow(ovf64)
    );

    seq_multiplier #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sg8),
        .mcand(a8), .b(b8), .busy(busy8), .done(done8),
        .prod(prod8), .overflow(ovf8)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: extend both operands to 128 bits and multiply as plain integers.
    task automatic model(input logic [63:0] a, input logic [63:0] bb, input int w, input bit sg,
                         output logic [127:0] p, output bit ov);
        logic signed [127:0] ea, eb, full, one, lim;
        logic [127:0] m, m2;
        m  = (128'd1 << w) - 128'd1;
        m2 = (w == 64) ? '1 : ((128'd1 << (2 * w)) - 128'd1);
        ea = a & m;
        eb = bb & m;
        if (sg && a[w-1])  ea = ea | ~m;
        if (sg && bb[w-1]) eb = eb | ~m;
        full = ea * eb;
        p    = full & m2;
        one  = 1;
        lim  = one << (w - 1);
        if (sg) ov = (full >= lim) || (full < -lim);
        else    ov = (full >> w) != 0;
    endtask

    task automatic drive(input int w, input op_t op, input logic st);
        if (w == 64) begin
            start64 = st; sg64 = op.sg; a64 = op.a; b64 = op.b;
        end else begin
            start8 = st; sg8 = op.sg; a8 = op.a[7:0]; b8 = op.b[7:0];
        end
    endtask

    function automatic logic [63:0] rnd_val(input int w);
        logic [63:0] m, v;
        m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = 64'd1;
            2:       v = m;
            3:       v = 64'd1 << (w - 1);
            4:       v = (64'd1 << (w - 1)) - 64'd1;
            default: v = {$urandom, $urandom};
        endcase
        return v & m;
    endfunction

    // One operation: start for one edge, then watch w+6 edges for busy/done/prod.
    // poke_k > 0 pulses a spurious start with other operands before edge poke_k.
    task automatic run_op(input int w, input op_t op, input int poke_k, input string tag);
        logic [127:0] ep, got_p;
        bit eo;
        logic got_o, bsy, dn;
        int first_done, n_done, busy_bad;
        op_t junk;
        model(op.a, op.b, w, op.sg, ep, eo);
        junk.a = ~op.a; junk.b = op.b ^ 64'h5; junk.sg = ~op.sg;
        drive(w, op, 1'b1);
        @(posedge clk); #1;
        drive(w, op, 1'b0);
        first_done = -1; n_done = 0; busy_bad = 0; got_p = '0; got_o = 1'b0;
        for (int k = 1; k <= w + 6; k++) begin
            if (k == poke_k) drive(w, junk, 1'b1);
            @(posedge clk); #1;
            if (k == poke_k) drive(w, op, 1'b0);
            bsy = (w == 64) ? busy64 : busy8;
            dn  = (w == 64) ? done64 : done8;
            if (bsy !== ((k >= 1) && (k <= w + 1))) busy_bad++;
            if (dn === 1'b1) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = k;
                    got_p = (w == 64) ? prod64 : {112'b0, prod8};
                    got_o = (w == 64) ? ovf64 : ovf8;
                end
            end
        end
        check({tag, " latency"}, 128'(first_done), 128'(w + 2));
        check({tag, " done_pulses"}, 128'(n_done), 128'd1);
        check({tag, " busy_window"}, 128'(busy_bad), 128'd0);
        check({tag, " prod"}, got_p, ep);
        check({tag, " overflow"}, 128'(got_o), 128'(eo));
        check({tag, " prod_hold"}, (w == 64) ? prod64 : {112'b0, prod8}, ep);
    endtask

    initial begin
        op_t op, op2;
        logic [127:0] ep1, ep2;
        bit eo1, eo2;
        int d_idx[2];
        logic [127:0] d_prod[2];
        logic d_ovf[2];
        int n_done;

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 128'(busy64), 128'd0);
        check("reset done", 128'(done64), 128'd0);
        check("reset prod", prod64, 128'd0);
        check("reset overflow", 128'(ovf64), 128'd0);
        check("reset8 prod", 128'(prod8), 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op.a = 64'h8000_0000_0000_0000; op.b = 64'h7FFF_FFFF_FFFF_FFFF; op.sg = 1'b1;
        run_op(64, op, 0, "min_x_max_s");
        op.a = '1; op.b = '1; op.sg = 1'b0;
        run_op(64, op, 0, "ones_u");
        op.sg = 1'b1;
        run_op(64, op, 0, "m1_x_m1_s");

        // Back-to-back: min*min, then 7*-3 accepted on the DONE cycle with start held high.
        op.a  = 64'h8000_0000_0000_0000; op.b = 64'h8000_0000_0000_0000; op.sg = 1'b1;
        op2.a = 64'd7; op2.b = 64'hFFFF_FFFF_FFFF_FFFD; op2.sg = 1'b1;
        model(op.a, op.b, 64, 1'b1, ep1, eo1);
        model(op2.a, op2.b, 64, 1'b1, ep2, eo2);
        check("model min_x_min", ep1, 128'h4000_0000_0000_0000_0000_0000_0000_0000);
        drive(64, op, 1'b1);
        @(posedge clk); #1;
        drive(64, op2, 1'b1);
        n_done = 0;
        d_idx[0] = -1; d_idx[1] = -1;
        d_prod[0] = '0; d_prod[1] = '0; d_ovf[0] = 1'b0; d_ovf[1] = 1'b0;
        for (int k = 1; k <= 2 * 64 + 8; k++) begin
            @(posedge clk); #1;
            if (k == 64 + 2) drive(64, op2, 1'b0);
            if (done64 === 1'b1) begin
                if (n_done < 2) begin
                    d_idx[n_done] = k; d_prod[n_done] = prod64; d_ovf[n_done] = ovf64;
                end
                n_done++;
            end
        end
        check("b2b done_count", 128'(n_done), 128'd2);
        check("b2b first_at", 128'(d_idx[0]), 128'd66);
        check("b2b second_at", 128'(d_idx[1]), 128'd132);
        check("b2b first_prod", d_prod[0], ep1);
        check("b2b first_ovf", 128'(d_ovf[0]), 128'(eo1));
        check("b2b second_prod", d_prod[1], ep2);
        check("b2b second_ovf", 128'(d_ovf[1]), 128'(eo2));

        // WIDTH=8 with a spurious start in the middle of CALC.
        op.a = 64'h80; op.b = 64'h80; op.sg = 1'b0;
        run_op(8, op, 4, "w8_ignore_start");

        // Reset in the middle of CALC aborts the operation.
        op.a = 64'h1234_5678_9ABC_DEF0; op.b = 64'h0FED_CBA9_8765_4321; op.sg = 1'b0;
        drive(64, op, 1'b1);
        @(posedge clk); #1;
        drive(64, op, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort busy", 128'(busy64), 128'd0);
        check("abort done", 128'(done64), 128'd0);
        check("abort prod", prod64, 128'd0);
        check("abort overflow", 128'(ovf64), 128'd0);
        n_done = 0;
        for (int k = 0; k < 70; k++) begin
            @(posedge clk); #1;
            if (done64 === 1'b1 || busy64 === 1'b1) n_done++;
        end
        check("abort no_activity", 128'(n_done), 128'd0);
        run_op(64, op, 0, "after_abort");

        for (int i = 0; i < 16; i++) begin
            op.a = rnd_val(64); op.b = rnd_val(64); op.sg = 1'($urandom_range(0, 1));
            run_op(64, op, 0, $sformatf("rand64_%0d", i));
        end
        for (int i = 0; i < 24; i++) begin
            op.a = rnd_val(8); op.b = rnd_val(8); op.sg = 1'($urandom_range(0, 1));
            run_op(8, op, 0, $sformatf("rand8_%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
